fll_bitclk_compare: RTL and testbench
=====================================

// Module: fll_bitclk_compare
// PURPOSE
//  Measures local I2S bit clock (Sys_Clk1-derived) against external master bit clock in FLL loop.
//  Counts local rising edges over a window of WINDOW master rising edges; both clocks sampled by fast WB_CLK.
//  Raises qualified speedup/slowdown requests; these drive FB_msg_out interrupts so firmware trims the local clock divider.
//  Sits inside AL4S3B_FPGA_IP, between the gclkbuff'd bit clocks and the interrupt outputs.
// PARAMETERS
//  CNT_W        16  width of window/edge counters
//  SYNC_STAGES  2   synchronizer flops per sampled clock (>=2)
// PORTS
//  WB_CLK             in   1      sample clock; must exceed 2x both bit clocks
//  WB_RST_n           in   1      reset, asynchronous assert, active-low
//  bitclk_master      in   1      external master bit clock, asynchronous
//  bitclk_local       in   1      local generated bit clock, asynchronous
//  enable_i           in   1      1 = run measurement loop
//  window_i           in   CNT_W  master edges per window (0 treated as 1)
//  deadband_i         in   8      allowed |local - window| without request
//  qual_i             in   4      consecutive same-direction windows before assert (0 treated as 1)
//  int_clr_i          in   1      1-cycle pulse: clear both interrupts and streaks
//  Interrupt_speedup  out  1      level: local clock slow, speed it up
//  Interrupt_slowdown out  1      level: local clock fast, slow it down
//  local_cnt_o        out  CNT_W  local edge count of last completed window
//  meas_valid_o       out  1      1-cycle pulse when local_cnt_o updates
//  busy_o             out  1      1 in ARM/MEASURE/EVAL
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters/streaks 0.
//  Sync: each bit clock via SYNC_STAGES flops + history flop; m_rise/l_rise = 1-cycle rising-edge pulses.
//   Edge-to-pulse latency SYNC_STAGES+1 cycles, identical for both clocks.
//  FSM IDLE -> ARM when enable_i=1. ARM: latch window_i/deadband_i/qual_i; wait first m_rise (not counted),
//   then MEASURE with m_cnt=0, l_cnt=0.
//  MEASURE: m_rise -> m_cnt+1; l_rise -> l_cnt+1, saturating at all-ones.
//   Window-ending m_rise (m_cnt+1==window) -> EVAL; l_rise in that cycle is counted.
//  EVAL (1 cycle): local_cnt_o<=l_cnt, meas_valid_o=1; diff=l_cnt-window, signed CNT_W+1 bits.
//   diff < -deadband: slow_streak=0, fast... -> sp_streak+1 (sat); if sp_streak+1>=qual set Interrupt_speedup, clr Interrupt_slowdown.
//   diff > +deadband: mirror (sd_streak, Interrupt_slowdown).
//   |diff|<=deadband (inclusive): both streaks 0, both interrupts 0.
//   Re-latch parameters; next window starts at ending edge: m_cnt=0, l_cnt=l_rise?1:0; -> MEASURE.
//  int_clr_i: clears interrupts and streaks; wins over an EVAL set in the same cycle.
//  enable_i=0 in any state: next cycle IDLE, counters/streaks/interrupts cleared, local_cnt_o held.
//  Parameter changes mid-window ignored until next EVAL/ARM.
//  Reset mid-window: immediate return to reset values; no meas_valid_o.
// TESTING
//  window=64, local=master freq, deadband=2, qual=1 -> meas_valid each window, local_cnt_o=64, no interrupts.
//  window=64, local 60 edges/window, deadband=2, qual=1 -> Interrupt_speedup=1 after first EVAL, local_cnt_o=60.
//  local 68 edges/window, qual=3 -> Interrupt_slowdown rises on 3rd EVAL only; 0 after 1st/2nd.
//  Speedup asserted, then window of 63 edges (deadband=2) -> Interrupt_speedup returns 0 at that EVAL.
//  int_clr_i coincident with EVAL setting speedup -> Interrupt_speedup stays 0, streak restarts at 0.
//  enable_i dropped mid-window, then re-raised -> busy_o=0 next cycle, no meas_valid, new window aligns to next m_rise.
//  window_i=0 -> treated as 1: EVAL every master edge; WB_RST_n low mid-MEASURE -> all outputs 0.

Source files
------------

// File: rtl/fll_bitclk_compare.sv
// fll_bitclk_compare: counts local bit-clock edges per master window and raises qualified speedup/slowdown requests
module fll_bitclk_compare #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             WB_CLK,
    input  logic             WB_RST_n,
    input  logic             bitclk_master,
    input  logic             bitclk_local,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] window_i,
    input  logic [7:0]       deadband_i,
    input  logic [3:0]       qual_i,
    input  logic             int_clr_i,
    output logic             Interrupt_speedup,
    output logic             Interrupt_slowdown,
    output logic [CNT_W-1:0] local_cnt_o,
    output logic             meas_valid_o,
    output logic             busy_o
);
    typedef enum logic [1:0] {IDLE, ARM, MEASURE, EVAL} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state_q, state_d;
    logic [SYNC_STAGES:0] m_sync_q, m_sync_d, l_sync_q, l_sync_d;
    logic [CNT_W-1:0]   win_q, win_d, m_cnt_q, m_cnt_d, l_cnt_q, l_cnt_d, cnt_out_q, cnt_out_d;
    logic [7:0]         db_q, db_d;
    logic [3:0]         qual_q, qual_d, sp_q, sp_d, sd_q, sd_d;
    logic               int_sp_q, int_sp_d, int_sd_q, int_sd_d, valid_q, valid_d;
    logic               m_rise, l_rise, slow, fast, sp_hit, sd_hit;
    logic [CNT_W-1:0]   win_in, l_inc;
    logic [3:0]         qual_in;
    logic [CNT_W+1:0]   l_wide, w_wide, db_wide;

    // Synchronizer shift chains; the top bit is the history flop for edge detection
    always_comb begin
        m_sync_d = {m_sync_q[SYNC_STAGES-1:0], bitclk_master};
        l_sync_d = {l_sync_q[SYNC_STAGES-1:0], bitclk_local};
    end

    assign m_rise  = m_sync_q[SYNC_STAGES-1] & ~m_sync_q[SYNC_STAGES];
    assign l_rise  = l_sync_q[SYNC_STAGES-1] & ~l_sync_q[SYNC_STAGES];
    assign win_in  = (window_i == '0) ? CNT_ONE : window_i;
    assign qual_in = (qual_i == 4'd0) ? 4'd1 : qual_i;
    assign l_inc   = (l_rise && l_cnt_q != '1) ? l_cnt_q + CNT_ONE : l_cnt_q;
    assign l_wide  = {2'b00, l_cnt_q};
    assign w_wide  = {2'b00, win_q};
    assign db_wide = (CNT_W+2)'(db_q);
    assign slow    = (l_wide + db_wide) < w_wide;
    assign fast    = l_wide > (w_wide + db_wide);
    assign sp_hit  = ({1'b0, sp_q} + 5'd1) >= {1'b0, qual_q};
    assign sd_hit  = ({1'b0, sd_q} + 5'd1) >= {1'b0, qual_q};

    // Measurement FSM: window counting, evaluation, streak qualification, clear/disable overrides
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        db_d      = db_q;
        qual_d    = qual_q;
        m_cnt_d   = m_cnt_q;
        l_cnt_d   = l_cnt_q;
        sp_d      = sp_q;
        sd_d      = sd_q;
        int_sp_d  = int_sp_q;
        int_sd_d  = int_sd_q;
        cnt_out_d = cnt_out_q;
        valid_d   = 1'b0;
        case (state_q)
            IDLE: state_d = enable_i ? ARM : IDLE;
            ARM: begin
                win_d  = win_in;
                db_d   = deadband_i;
                qual_d = qual_in;
                if (m_rise) begin
                    state_d = MEASURE;
                    m_cnt_d = '0;
                    l_cnt_d = '0;
                end
            end
            MEASURE: begin
                l_cnt_d = l_inc;
                if (m_rise) begin
                    m_cnt_d = m_cnt_q + CNT_ONE;
                    state_d = (m_cnt_q + CNT_ONE == win_q) ? EVAL : MEASURE;
                end
            end
            EVAL: begin
                valid_d   = 1'b1;
                cnt_out_d = l_cnt_q;
                win_d     = win_in;
                db_d      = deadband_i;
                qual_d    = qual_in;
                m_cnt_d   = '0;
                l_cnt_d   = l_rise ? CNT_ONE : '0;
                state_d   = MEASURE;
                if (slow) begin
                    sd_d = 4'd0;
                    sp_d = (sp_q == 4'hf) ? sp_q : sp_q + 4'd1;
                    if (sp_hit) begin
                        int_sp_d = 1'b1;
                        int_sd_d = 1'b0;
                    end
                end else if (fast) begin
                    sp_d = 4'd0;
                    sd_d = (sd_q == 4'hf) ? sd_q : sd_q + 4'd1;
                    if (sd_hit) begin
                        int_sd_d = 1'b1;
                        int_sp_d = 1'b0;
                    end
                end else begin
                    sp_d     = 4'd0;
                    sd_d     = 4'd0;
                    int_sp_d = 1'b0;
                    int_sd_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (int_clr_i) begin
            sp_d     = 4'd0;
            sd_d     = 4'd0;
            int_sp_d = 1'b0;
            int_sd_d = 1'b0;
        end
        if (!enable_i) begin
            state_d   = IDLE;
            m_cnt_d   = '0;
            l_cnt_d   = '0;
            sp_d      = 4'd0;
            sd_d      = 4'd0;
            int_sp_d  = 1'b0;
            int_sd_d  = 1'b0;
            valid_d   = 1'b0;
            cnt_out_d = cnt_out_q;
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            state_q   <= IDLE;
            m_sync_q  <= '0;
            l_sync_q  <= '0;
            win_q     <= '0;
            db_q      <= '0;
            qual_q    <= '0;
            m_cnt_q   <= '0;
            l_cnt_q   <= '0;
            sp_q      <= '0;
            sd_q      <= '0;
            int_sp_q  <= 1'b0;
            int_sd_q  <= 1'b0;
            cnt_out_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_sync_q  <= m_sync_d;
            l_sync_q  <= l_sync_d;
            win_q     <= win_d;
            db_q      <= db_d;
            qual_q    <= qual_d;
            m_cnt_q   <= m_cnt_d;
            l_cnt_q   <= l_cnt_d;
            sp_q      <= sp_d;
            sd_q      <= sd_d;
            int_sp_q  <= int_sp_d;
            int_sd_q  <= int_sd_d;
            cnt_out_q <= cnt_out_d;
            valid_q   <= valid_d;
        end
    end

    assign Interrupt_speedup  = int_sp_q;
    assign Interrupt_slowdown = int_sd_q;
    assign local_cnt_o        = cnt_out_q;
    assign meas_valid_o       = valid_q;
    assign busy_o             = (state_q != IDLE);
endmodule

// File: tb/tb_fll_bitclk_compare.sv
// tb_fll_bitclk_compare: randomized window measurements checked against an edge-counting reference model
module tb_fll_bitclk_compare;
    localparam int MAXC = 8192;

    logic        WB_CLK = 1'b0;
    logic        WB_RST_n = 1'b0;
    logic        bitclk_master = 1'b0;
    logic        bitclk_local = 1'b0;
    logic        enable_i = 1'b0;
    logic [15:0] window_i = '0;
    logic [7:0]  deadband_i = '0;
    logic [3:0]  qual_i = '0;
    logic        int_clr_i = 1'b0;
    logic        Interrupt_speedup, Interrupt_slowdown, meas_valid_o, busy_o;
    logic [15:0] local_cnt_o;

    typedef struct {
        logic [15:0] cnt;
        logic        sp;
        logic        sd;
    } res_t;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] last_cnt = '0;
    res_t        obs_q[$];
    res_t        exp_q[$];
    int          end_cyc[$];
    bit          m_lv[MAXC];
    bit          l_lv[MAXC];

    fll_bitclk_compare #(.CNT_W(16), .SYNC_STAGES(2)) dut (
        .WB_CLK(WB_CLK), .WB_RST_n(WB_RST_n),
        .bitclk_master(bitclk_master), .bitclk_local(bitclk_local),
        .enable_i(enable_i), .window_i(window_i), .deadband_i(deadband_i),
        .qual_i(qual_i), .int_clr_i(int_clr_i),
        .Interrupt_speedup(Interrupt_speedup), .Interrupt_slowdown(Interrupt_slowdown),
        .local_cnt_o(local_cnt_o), .meas_valid_o(meas_valid_o), .busy_o(busy_o)
    );

    always #5 WB_CLK = ~WB_CLK;

    always @(negedge WB_CLK)
        if (meas_valid_o === 1'b1)
            obs_q.push_back('{cnt: local_cnt_o, sp: Interrupt_speedup, sd: Interrupt_slowdown});

    function automatic logic [31:0] step(input int r, input int hm);
        return 32'((64'(r) << 32) / 64'(128 * hm));
    endfunction

    // One measurement run: precompute bit clocks, predict every window, drive, compare, then disable
    task automatic run_windows(input string name, input int w, input int db, input int q,
                               input int ncyc, input int hm, input logic [31:0] ls1,
                               input logic [31:0] ls2, input int sw, input int chg_w,
                               input int clr_idx);
        int          mph, c_chg, nr, m, l, wsz, sp, sd, idx, d, qe, cur_w, cl_lo, cl_hi, n;
        logic [31:0] acc;
        bit          pm, pl, armed, mr, lr, isp, isd;
        mph = $urandom_range(0, 2 * hm - 1);
        acc = $urandom;
        for (int k = 0; k < ncyc; k++) begin
            m_lv[k] = (((k + mph) / hm) % 2) == 1;
            acc = acc + ((k < sw) ? ls1 : ls2);
            l_lv[k] = acc[31];
        end
        c_chg = ncyc + 100;
        nr = 0;
        pm = 0;
        for (int k = 0; k < ncyc; k++) begin
            if (m_lv[k] && !pm) begin
                if (nr == 1 && chg_w >= 0) c_chg = k + hm;
                nr++;
            end
            pm = m_lv[k];
        end
        exp_q.delete();
        end_cyc.delete();
        pm = 0; pl = 0; armed = 0; isp = 0; isd = 0;
        m = 0; l = 0; wsz = 0; sp = 0; sd = 0; idx = 0;
        qe = (q == 0) ? 1 : q;
        for (int k = 0; k < ncyc; k++) begin
            mr = m_lv[k] && !pm;
            lr = l_lv[k] && !pl;
            pm = m_lv[k];
            pl = l_lv[k];
            cur_w = (k >= c_chg) ? chg_w : w;
            if (cur_w == 0) cur_w = 1;
            if (!armed) begin
                if (mr) begin
                    armed = 1; m = 0; l = 0; wsz = cur_w;
                end
            end else begin
                if (lr && l < 65535) l++;
                if (mr) begin
                    m++;
                    if (m == wsz) begin
                        d = l - wsz;
                        if (d < -db) begin
                            sd = 0; sp++;
                            if (sp >= qe) begin isp = 1; isd = 0; end
                        end else if (d > db) begin
                            sp = 0; sd++;
                            if (sd >= qe) begin isd = 1; isp = 0; end
                        end else begin
                            sp = 0; sd = 0; isp = 0; isd = 0;
                        end
                        if (idx == clr_idx) begin
                            sp = 0; sd = 0; isp = 0; isd = 0;
                        end
                        exp_q.push_back('{cnt: 16'(l), sp: isp, sd: isd});
                        end_cyc.push_back(k);
                        idx++; m = 0; l = 0; wsz = cur_w;
                    end
                end
            end
        end
        cl_lo = -100;
        cl_hi = -100;
        if (clr_idx >= 0 && clr_idx < end_cyc.size()) begin
            cl_lo = end_cyc[clr_idx] - 2;
            cl_hi = end_cyc[clr_idx] + 8;
        end
        @(negedge WB_CLK);
        obs_q.delete();
        window_i = 16'(w);
        deadband_i = 8'(db);
        qual_i = 4'(q);
        enable_i = 1'b1;
        repeat (4) @(negedge WB_CLK);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge WB_CLK);
            bitclk_master = m_lv[k];
            bitclk_local = l_lv[k];
            int_clr_i = (k >= cl_lo && k <= cl_hi);
            if (k == c_chg) window_i = 16'(chg_w);
        end
        @(negedge WB_CLK);
        bitclk_master = 1'b0;
        bitclk_local = 1'b0;
        int_clr_i = 1'b0;
        repeat (10) @(negedge WB_CLK);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s window_count got=%0d exp=%0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].cnt !== exp_q[i].cnt || obs_q[i].sp !== exp_q[i].sp || obs_q[i].sd !== exp_q[i].sd) begin
                failures++;
                $display("FAIL %s window[%0d] got cnt=%0d sp=%b sd=%b exp cnt=%0d sp=%b sd=%b", name, i,
                         obs_q[i].cnt, obs_q[i].sp, obs_q[i].sd, exp_q[i].cnt, exp_q[i].sp, exp_q[i].sd);
            end
        end
        if (exp_q.size() > 0) last_cnt = exp_q[exp_q.size()-1].cnt;
        n = obs_q.size();
        enable_i = 1'b0;
        @(negedge WB_CLK);
        checks++;
        if (busy_o !== 1'b0 || Interrupt_speedup !== 1'b0 || Interrupt_slowdown !== 1'b0 || local_cnt_o !== last_cnt) begin
            failures++;
            $display("FAIL %s disable got busy=%b sp=%b sd=%b cnt=%0d exp busy=0 sp=0 sd=0 cnt=%0d", name,
                     busy_o, Interrupt_speedup, Interrupt_slowdown, local_cnt_o, last_cnt);
        end
        repeat (6) @(negedge WB_CLK);
        checks++;
        if (obs_q.size() != n) begin
            failures++;
            $display("FAIL %s valid_after_disable got=%0d exp=%0d", name, obs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (Interrupt_speedup !== 1'b0 || Interrupt_slowdown !== 1'b0 || local_cnt_o !== 16'd0 || meas_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset got sp=%b sd=%b cnt=%0d valid=%b busy=%b exp all 0", Interrupt_speedup,
                     Interrupt_slowdown, local_cnt_o, meas_valid_o, busy_o);
        end
        @(negedge WB_CLK);
        WB_RST_n = 1'b1;
        repeat (3) @(negedge WB_CLK);
        checks++;
        if (busy_o !== 1'b0 || meas_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got busy=%b valid=%b exp 0 0", busy_o, meas_valid_o);
        end
    endtask

    task automatic test_match();
        run_windows("match", 64, 2, 1, 64 * 8 * 3 + 200, 4, step(64, 4), step(64, 4), MAXC, -1, -1);
    endtask

    task automatic test_speedup();
        run_windows("speedup", 64, 2, 1, 64 * 8 * 3 + 200, 4, step(60, 4), step(60, 4), MAXC, -1, -1);
    endtask

    task automatic test_slowdown_qual();
        run_windows("slowdown_qual", 64, 2, 3, 64 * 8 * 4 + 300, 4, step(68, 4), step(68, 4), MAXC, -1, -1);
    endtask

    task automatic test_recover();
        run_windows("recover", 64, 2, 1, 64 * 8 * 6 + 200, 4, step(60, 4), step(63, 4), 64 * 8 * 3, -1, -1);
    endtask

    task automatic test_int_clr();
        run_windows("int_clr", 16, 2, 2, 16 * 8 * 5 + 60, 4, step(48, 4), step(48, 4), MAXC, -1, 1);
    endtask

    task automatic test_param_change();
        run_windows("param_change", 16, 1, 1, 16 * 6 * 5 + 40, 3, step(70, 3), step(70, 3), MAXC, 24, -1);
    endtask

    task automatic test_window_zero();
        run_windows("window_zero_eq", 0, 0, 1, 200, 4, step(64, 4), step(64, 4), MAXC, -1, -1);
        run_windows("window_zero_fast", 0, 0, 1, 200, 4, step(130, 4), step(130, 4), MAXC, -1, -1);
    endtask

    task automatic test_back_to_back();
        int w, hm, r;
        for (int i = 0; i < 3; i++) begin
            w = $urandom_range(8, 24);
            hm = $urandom_range(3, 4);
            r = $urandom_range(40, 90);
            run_windows("random", w, $urandom_range(0, 4), $urandom_range(0, 3),
                        w * 2 * hm * 4 + $urandom_range(5, w * hm), hm, step(r, hm), step(r, hm), MAXC, -1, -1);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge WB_CLK);
        window_i = 16'd4;
        deadband_i = 8'd0;
        qual_i = 4'd1;
        enable_i = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge WB_CLK);
            bitclk_master = ((k / 4) % 2) == 1;
            bitclk_local = ((k / 8) % 2) == 1;
        end
        checks++;
        if (Interrupt_speedup !== 1'b1 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre got sp=%b busy=%b exp 1 1", Interrupt_speedup, busy_o);
        end
        #2 WB_RST_n = 1'b0;
        #1;
        checks++;
        if (Interrupt_speedup !== 1'b0 || Interrupt_slowdown !== 1'b0 || local_cnt_o !== 16'd0 || meas_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got sp=%b sd=%b cnt=%0d valid=%b busy=%b exp all 0", Interrupt_speedup,
                     Interrupt_slowdown, local_cnt_o, meas_valid_o, busy_o);
        end
        @(negedge WB_CLK);
        enable_i = 1'b0;
        bitclk_master = 1'b0;
        bitclk_local = 1'b0;
        WB_RST_n = 1'b1;
        last_cnt = '0;
        repeat (6) @(negedge WB_CLK);
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_match();
        test_speedup();
        test_slowdown_qual();
        test_recover();
        test_int_clr();
        test_param_change();
        test_window_zero();
        test_back_to_back();
        test_reset_mid();
        test_match();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
